// File: rtl/debug_uart_pkg.sv
// Shared constants, state encodings and the nibble-to-ASCII helper for the
// debug register UART dump.
package debug_uart_pkg;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int MSG_BYTES     = 46;
    localparam int CHARS_PER_REG = 8;
    localparam int NUM_REGS      = 5;

    // Index of the final byte (LF) of the message.
    localparam logic [5:0] LAST_IDX = 6'(MSG_BYTES - 1);

    // Message sequencer states.
    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_LOAD,
        SEQ_SEND,
        SEQ_FINISH
    } seq_state_e;

    // Byte serializer states.
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } ser_state_e;

    // 0-9 -> '0'-'9', A-F -> 'A'-'F' (uppercase).
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end else begin
            return 8'h37 + {4'h0, nib};
        end
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. Ready is combinational and also true on the last cycle
// of a stop bit, so a Load on that edge chains the next frame with no gap.
module uart_tx_byte
    import debug_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       ClkIn,
    input  logic       Reset,
    input  logic [7:0] Data,
    input  logic       Load,
    output logic       Tx,
    output logic       Ready,
    output logic       ByteDone
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    ser_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    assign bit_end  = (cnt_q == CNT_LAST);
    assign ByteDone = (state_q == S_STOP) && bit_end;
    assign Ready    = (state_q == S_IDLE) || ByteDone;
    assign Tx       = tx_q;

    // Serializer next-state: bit-period counting, bit index and line level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        if (Load && Ready) begin
            state_d = S_START;
            cnt_d   = '0;
            bit_d   = '0;
            shift_d = Data;
            tx_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    tx_d  = 1'b1;
                end
                S_START: begin
                    if (bit_end) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        bit_d   = '0;
                        tx_d    = shift_q[0];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt_d = '0;
                        if (bit_q == 3'd7) begin
                            state_d = S_STOP;
                            bit_d   = '0;
                            tx_d    = 1'b1;
                        end else begin
                            bit_d   = bit_q + 3'd1;
                            shift_d = {1'b0, shift_q[7:1]};
                            tx_d    = shift_q[1];
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        tx_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                end
            endcase
        end
    end

    // Serializer registers; the line idles high out of reset.
    always_ff @(posedge ClkIn or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/debug_uart_dump.sv
// Snapshots Reg19..Reg23 on Start and streams them as uppercase ASCII hex
// ("XXXXXXXX " x4, "XXXXXXXX\r\n") over an 8N1 UART line.
module debug_uart_dump
    import debug_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        ClkIn,
    input  logic        Reset,
    input  logic        Start,
    input  logic [31:0] Reg19,
    input  logic [31:0] Reg20,
    input  logic [31:0] Reg21,
    input  logic [31:0] Reg22,
    input  logic [31:0] Reg23,
    output logic        Tx,
    output logic        Busy,
    output logic        Done
);

    seq_state_e                 state_q, state_d;
    logic [5:0]                 idx_q, idx_d;
    logic [NUM_REGS-1:0][31:0]  snap_q, snap_d;
    logic                       done_q, done_d;

    logic       tx_load;
    logic       tx_ready;
    logic       byte_done;
    logic [7:0] tx_char;

    logic [2:0]  grp;
    logic [3:0]  pos;
    logic [31:0] cur_reg;
    logic [3:0]  nib;

    assign Busy = (state_q != SEQ_IDLE);
    assign Done = done_q;

    // Split the byte index into register group (0..4) and position (0..8).
    always_comb begin
        grp = 3'd0;
        pos = 4'd0;
        if (idx_q < 6'd9) begin
            grp = 3'd0;
            pos = idx_q[3:0];
        end else if (idx_q < 6'd18) begin
            grp = 3'd1;
            pos = 4'(idx_q - 6'd9);
        end else if (idx_q < 6'd27) begin
            grp = 3'd2;
            pos = 4'(idx_q - 6'd18);
        end else if (idx_q < 6'd36) begin
            grp = 3'd3;
            pos = 4'(idx_q - 6'd27);
        end else begin
            grp = 3'd4;
            pos = 4'(idx_q - 6'd36);
        end
    end

    // Character mux. Byte 0 is loaded on the accepting edge, before the
    // snapshot exists, so while idle it reads Reg19 directly.
    always_comb begin
        cur_reg = snap_q[0];
        nib     = 4'h0;
        tx_char = ASCII_SPACE;
        if (state_q == SEQ_IDLE) begin
            cur_reg = Reg19;
        end else begin
            case (grp)
                3'd0:    cur_reg = snap_q[0];
                3'd1:    cur_reg = snap_q[1];
                3'd2:    cur_reg = snap_q[2];
                3'd3:    cur_reg = snap_q[3];
                default: cur_reg = snap_q[4];
            endcase
        end
        case (pos[2:0])
            3'd0:    nib = cur_reg[31:28];
            3'd1:    nib = cur_reg[27:24];
            3'd2:    nib = cur_reg[23:20];
            3'd3:    nib = cur_reg[19:16];
            3'd4:    nib = cur_reg[15:12];
            3'd5:    nib = cur_reg[11:8];
            3'd6:    nib = cur_reg[7:4];
            default: nib = cur_reg[3:0];
        endcase
        if (idx_q == LAST_IDX) begin
            tx_char = ASCII_LF;
        end else if (pos == 4'(CHARS_PER_REG)) begin
            tx_char = (grp == 3'd4) ? ASCII_CR : ASCII_SPACE;
        end else begin
            tx_char = nibble_to_ascii(nib);
        end
    end

    // Sequencer: accept Start when idle, then hand one byte per frame to the
    // serializer; LOAD advances the index while the start bit goes out.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        done_d  = 1'b0;
        tx_load = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                idx_d = '0;
                if (Start && tx_ready) begin
                    tx_load = 1'b1;
                    snap_d  = {Reg23, Reg22, Reg21, Reg20, Reg19};
                    state_d = SEQ_LOAD;
                end
            end
            SEQ_LOAD: begin
                if (idx_q == LAST_IDX) begin
                    state_d = SEQ_FINISH;
                end else begin
                    idx_d   = idx_q + 6'd1;
                    state_d = SEQ_SEND;
                end
            end
            SEQ_SEND: begin
                if (byte_done && tx_ready) begin
                    tx_load = 1'b1;
                    state_d = SEQ_LOAD;
                end
            end
            SEQ_FINISH: begin
                if (byte_done) begin
                    idx_d   = '0;
                    done_d  = 1'b1;
                    state_d = SEQ_IDLE;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = SEQ_IDLE;
            end
        endcase
    end

    // Sequencer, snapshot and Done registers.
    always_ff @(posedge ClkIn or posedge Reset) begin
        if (Reset) begin
            state_q <= SEQ_IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            done_q  <= done_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .ClkIn   (ClkIn),
        .Reset   (Reset),
        .Data    (tx_char),
        .Load    (tx_load),
        .Tx      (Tx),
        .Ready   (tx_ready),
        .ByteDone(byte_done)
    );

endmodule

// File: tb/tb_debug_uart_dump.sv
// Bench for debug_uart_dump at CLKS_PER_BIT = 4: each dump's Tx waveform is
// compared frame by frame against an expected byte queue built from the
// register values, plus Busy/Done timing and reset behaviour.
module tb_debug_uart_dump;

    localparam int CPB         = 4;
    localparam int FW          = 10 * CPB;
    localparam int NBYTES      = 46;
    localparam int DUMP_CYCLES = 460 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] r19 = '0, r20 = '0, r21 = '0, r22 = '0, r23 = '0;
    logic        tx, busy, done;

    int n_cmp  = 0;
    int n_fail = 0;
    int stim_mode = 0;

    logic [31:0] exp_regs [5];
    logic [7:0]  exp_q [$];

    always #5 clk = ~clk;

    debug_uart_dump #(.CLKS_PER_BIT(CPB)) dut (
        .ClkIn(clk), .Reset(rst), .Start(start),
        .Reg19(r19), .Reg20(r20), .Reg21(r21), .Reg22(r22), .Reg23(r23),
        .Tx(tx), .Busy(busy), .Done(done)
    );

    // Expected message: 8 uppercase hex digits per register, separators after.
    task automatic build_expected();
        exp_q.delete();
        for (int r = 0; r < 5; r++) begin
            for (int n = 7; n >= 0; n--) begin
                int v;
                v = int'((exp_regs[r] >> (4 * n)) & 32'hF);
                exp_q.push_back(v < 10 ? 8'(48 + v) : 8'(65 + v - 10));
            end
            if (r < 4) begin
                exp_q.push_back(8'h20);
            end else begin
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
            end
        end
    endtask

    // Drive registers and the start request; called at a falling edge.
    task automatic launch(input logic [31:0] a, b, c, d, e);
        r19 = a; r20 = b; r21 = c; r22 = d; r23 = e;
        exp_regs[0] = a; exp_regs[1] = b; exp_regs[2] = c;
        exp_regs[3] = d; exp_regs[4] = e;
        build_expected();
        start = 1'b1;
    endtask

    // Per-cycle input perturbation during a dump (g = cycles since accept).
    task automatic apply_stim(input int g);
        case (stim_mode)
            1: begin
                start = 1'b0;
                if (g == 100) begin
                    r19 = 32'hAAAAAAAA; r20 = 32'hAAAAAAAA; r21 = 32'hAAAAAAAA;
                    r22 = 32'hAAAAAAAA; r23 = 32'hAAAAAAAA;
                end
            end
            2: start = (g == 49) || (g == 999) || (g == DUMP_CYCLES - 1);
            3: start = (g == DUMP_CYCLES);
            4: start = 1'b1;
            default: start = 1'b0;
        endcase
    endtask

    // Checks one dump whose accepting edge is the next rising edge.
    task automatic check_dump(input string name);
        logic [FW-1:0] got, want;
        logic [7:0]    b;
        int busy_bad, done_bad, g;
        busy_bad = 0; done_bad = 0; g = 0;
        for (int k = 0; k < NBYTES; k++) begin
            b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            for (int c = 0; c < FW; c++) begin
                want[c] = (c < CPB) ? 1'b0 : (c >= 9 * CPB) ? 1'b1 : b[(c / CPB) - 1];
                @(negedge clk);
                got[c] = tx;
                if (busy !== 1'b1) busy_bad++;
                if (done !== 1'b0) done_bad++;
                apply_stim(g);
                g++;
            end
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s byte %0d: tx frame %h, required %h (char %h)",
                         name, k, got, want, b);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_end: busy %b, required 0", name, busy);
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_pulse: done %b, required 1", name, done);
        end
        n_cmp++;
        if (tx !== 1'b1) begin
            n_fail++;
            $display("FAIL %s tx_end: tx %b, required 1", name, tx);
        end
        apply_stim(g);
        n_cmp++;
        if (busy_bad !== 0) begin
            n_fail++;
            $display("FAIL %s busy_span: %0d cycles low, required 0", name, busy_bad);
        end
        n_cmp++;
        if (done_bad !== 0) begin
            n_fail++;
            $display("FAIL %s done_early: %0d cycles high, required 0", name, done_bad);
        end
    endtask

    // Line must stay idle (Tx=1, Busy=0, Done=0) for n cycles.
    task automatic check_idle(input string name, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL %s idle: %0d non-idle cycles, required 0", name, bad);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: %b, required 1", tx); end
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: %b, required 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: %b, required 0", done); end
    endtask

    // Start raised together with reset release: first edge must accept it.
    task automatic test_byte_framing();
        stim_mode = 0;
        launch(32'h00000001, 32'h0, 32'h0, 32'h0, 32'h0);
        rst = 1'b0;
        check_dump("framing");
        check_idle("framing", 5);
    endtask

    task automatic test_full_message();
        stim_mode = 0;
        launch(32'h12345678, 32'h9ABCDEF0, 32'h00000000, 32'hFFFFFFFF, 32'hDEADBEEF);
        check_dump("full_msg");
        check_idle("full_msg", 5);
    endtask

    task automatic test_snapshot();
        stim_mode = 1;
        launch($urandom, $urandom, $urandom, $urandom, $urandom);
        check_dump("snapshot");
        stim_mode = 0;
        check_idle("snapshot", 5);
    endtask

    task automatic test_start_while_busy();
        stim_mode = 2;
        launch($urandom, $urandom, $urandom, $urandom, $urandom);
        check_dump("busy_start");
        stim_mode = 0;
        start = 1'b0;
        check_idle("busy_start", 30);
    endtask

    task automatic test_restart();
        stim_mode = 3;
        launch($urandom, $urandom, $urandom, $urandom, $urandom);
        check_dump("restart_a");
        stim_mode = 0;
        build_expected();
        check_dump("restart_b");
        check_idle("restart", 5);
    endtask

    task automatic test_mid_reset();
        stim_mode = 0;
        launch($urandom, $urandom, $urandom, $urandom, $urandom);
        for (int i = 0; i < 333; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL midrst_tx: %b, required 1", tx); end
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: %b, required 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: %b, required 0", done); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_idle("midrst", 20);
        launch($urandom, $urandom, $urandom, $urandom, $urandom);
        check_dump("midrst_after");
        check_idle("midrst_after", 5);
    endtask

    task automatic test_back_to_back();
        stim_mode = 4;
        launch($urandom, $urandom, $urandom, $urandom, $urandom);
        for (int i = 0; i < 3; i++) begin
            check_dump("b2b");
            if (i < 2) begin
                launch($urandom, $urandom, $urandom, $urandom, $urandom);
            end
        end
        stim_mode = 0;
        start = 1'b0;
        check_idle("b2b", 10);
    endtask

    task automatic test_random();
        stim_mode = 0;
        for (int i = 0; i < 2; i++) begin
            launch($urandom, $urandom, $urandom, $urandom, $urandom);
            check_dump("random");
            check_idle("random", $urandom_range(1, 8));
        end
    endtask

    initial begin
        test_reset();
        test_byte_framing();
        test_full_message();
        test_snapshot();
        test_start_while_busy();
        test_restart();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
